// File: rtl/risc_machine_mc.sv
// risc_machine_mc: multicycle 16-bit-encoded RISC core with a ready/wait memory port.
// Define RISC_BRANCH_EN to decode opcode 001 as conditional branches; otherwise 001 is illegal.
module risc_machine_mc #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] start_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] out,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        flags,
    output logic              halted,
    output logic              illegal
);

    // LOAD pc<-start_pc | FETCH read IR | DECODE read regs | EXEC alu/addr
    // MEM load/store handshake | WB load writeback | HALT stopped until reset
    typedef enum logic [2:0] {S_LOAD, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, data_q, data_d, out_q, out_d;
    logic [2:0]        flags_q, flags_d;
    logic              illegal_q, illegal_d;

    logic [DATA_W-1:0] rf_q [8];
    logic              rf_we;
    logic [2:0]        rf_wa;
    logic [DATA_W-1:0] rf_wd;

    logic [2:0]        opc;
    logic [1:0]        op;
    logic              is_movi, is_movr, is_add, is_cmp, is_and, is_mvn, is_ldr, is_str, is_hlt;
    logic              br_ok, br_take;
    logic [ADDR_W-1:0] br_off;
    logic [DATA_W-1:0] imm_sx, b_sh, diff, alu_res;

    assign opc     = ir_q[15:13];
    assign op      = ir_q[12:11];
    assign is_movi = (opc == 3'b110) && (op == 2'b10);
    assign is_movr = (opc == 3'b110) && (op == 2'b00);
    assign is_add  = (opc == 3'b101) && (op == 2'b00);
    assign is_cmp  = (opc == 3'b101) && (op == 2'b01);
    assign is_and  = (opc == 3'b101) && (op == 2'b10);
    assign is_mvn  = (opc == 3'b101) && (op == 2'b11);
    assign is_ldr  = (opc == 3'b011) && (op == 2'b00);
    assign is_str  = (opc == 3'b100) && (op == 2'b00);
    assign is_hlt  = (opc == 3'b111) && (op == 2'b00);
    assign imm_sx  = DATA_W'($signed(ir_q[7:0]));
    assign br_off  = ADDR_W'($signed(ir_q[7:0]));

`ifdef RISC_BRANCH_EN
    assign br_ok = (opc == 3'b001) && (ir_q[10:8] <= 3'd4);
    always_comb begin
        br_take = 1'b0;
        case (ir_q[10:8])
            3'd0:    br_take = 1'b1;
            3'd1:    br_take = flags_q[0];
            3'd2:    br_take = !flags_q[0];
            3'd3:    br_take = flags_q[2] ^ flags_q[1];
            3'd4:    br_take = flags_q[0] | (flags_q[2] ^ flags_q[1]);
            default: br_take = 1'b0;
        endcase
    end
`else
    assign br_ok   = 1'b0;
    assign br_take = 1'b0;
`endif

    always_comb begin
        case (ir_q[4:3])
            2'b01:   b_sh = {b_q[DATA_W-2:0], 1'b0};
            2'b10:   b_sh = {1'b0, b_q[DATA_W-1:1]};
            2'b11:   b_sh = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
            default: b_sh = b_q;
        endcase
        diff = a_q - b_sh;
        case (op)
            2'b00:   alu_res = (opc == 3'b110) ? b_sh : a_q + b_sh;
            2'b10:   alu_res = a_q & b_sh;
            default: alu_res = ~b_sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LOAD;
            ir_q      <= '0;
            pc_q      <= '0;
            addr_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            data_q    <= '0;
            out_q     <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            data_q    <= data_d;
            out_q     <= out_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    // Register file is deliberately not reset: contents survive a core reset.
    always_ff @(posedge clk) begin
        if (rf_we) rf_q[rf_wa] <= rf_wd;
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        data_d    = data_q;
        out_d     = out_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        rf_wa     = ir_q[7:5];
        rf_wd     = alu_res;
        case (state_q)
            S_LOAD: begin
                pc_d    = start_pc;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata[15:0];
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[ir_q[10:8]];
                b_d     = rf_q[ir_q[2:0]];
                c_d     = rf_q[ir_q[7:5]];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (is_movi) begin
                    rf_we = 1'b1;
                    rf_wa = ir_q[10:8];
                    rf_wd = imm_sx;
                    out_d = imm_sx;
                end else if (is_movr || is_add || is_and || is_mvn) begin
                    rf_we = 1'b1;
                    out_d = alu_res;
                end else if (is_cmp) begin
                    flags_d = {diff[DATA_W-1],
                               (a_q[DATA_W-1] != b_sh[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]),
                               diff == '0};
                end else if (is_ldr || is_str) begin
                    addr_d  = a_q[ADDR_W-1:0] + ADDR_W'(ir_q[4:0]);
                    state_d = S_MEM;
                end else if (is_hlt) begin
                    state_d = S_HALT;
                end else if (br_ok) begin
                    if (br_take) pc_d = pc_q + br_off;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (is_ldr) begin
                        data_d  = mem_rdata;
                        state_d = S_WB;
                    end else begin
                        out_d   = c_q;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_wd   = data_q;
                out_d   = data_q;
                state_d = S_FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        halted    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = pc_q;
            end
            S_MEM: begin
                mem_addr = addr_q;
                if (is_ldr) begin
                    mem_rd = 1'b1;
                end else begin
                    mem_wr    = 1'b1;
                    mem_wdata = c_q;
                end
            end
            S_HALT:  halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

    assign out     = out_q;
    assign pc      = pc_q;
    assign flags   = flags_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_risc_machine_mc.sv
// Directed bench for risc_machine_mc: small programs in a wait-state-capable memory model.
`timescale 1ns/1ps
module tb_risc_machine_mc;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam logic [15:0] HALT = 16'hE000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] start_pc;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd, mem_wr, mem_ready;
    logic [DATA_W-1:0] mem_wdata, mem_rdata, out;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        flags;
    logic              halted, illegal;

    logic [15:0] mem [256];
    int          wait_cfg = 0;
    int          stall_cnt = 0;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [7:0]  ld_ptr = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    risc_machine_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_pc(start_pc),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .out(out), .pc(pc), .flags(flags), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign mem_ready = (stall_cnt >= wait_cfg);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= 0;
        else if (mem_rd || mem_wr) stall_cnt <= mem_ready ? 0 : stall_cnt + 1;
    end

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (rst_n && mem_wr && mem_ready) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic org(input logic [7:0] a);
        ld_ptr = a;
    endtask

    task automatic put(input logic [15:0] w);
        ld_addr = ld_ptr;
        ld_data = w;
        ld_en   = 1'b1;
        @(posedge clk);
        #1;
        ld_en   = 1'b0;
        ld_ptr  = ld_ptr + 8'd1;
    endtask

    task automatic do_reset(input logic [7:0] spc, input int wc);
        @(negedge clk);
        rst_n    = 1'b0;
        start_pc = spc;
        wait_cfg = wc;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_halt(input int max);
        int cyc;
        cyc = 0;
        while (!halted && cyc < max) begin
            step(1);
            cyc++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    function automatic logic [15:0] enc(input logic [2:0] opc, input logic [1:0] op,
                                        input logic [2:0] rn, input logic [2:0] rd,
                                        input logic [1:0] sh, input logic [2:0] rm);
        return {opc, op, rn, rd, sh, rm};
    endfunction

    function automatic logic [15:0] movi(input logic [2:0] rn, input logic [7:0] imm);
        return {3'b110, 2'b10, rn, imm};
    endfunction

    function automatic logic [15:0] ldst(input logic [2:0] opc, input logic [2:0] rd,
                                         input logic [2:0] rn, input logic [4:0] imm5);
        return {opc, 2'b00, rn, rd, imm5};
    endfunction

    initial begin
        rst_n    = 1'b1;
        start_pc = '0;
        #1 rst_n = 1'b0;

        org(8'd0);   put(movi(3'd1, 8'd5)); put(movi(3'd2, 8'd7)); put(HALT);
        org(8'd8);   put(enc(3'b101, 2'b00, 3'd1, 3'd3, 2'b00, 3'd2));
                     put(enc(3'b101, 2'b10, 3'd1, 3'd4, 2'b00, 3'd2));
                     put(enc(3'b101, 2'b11, 3'd0, 3'd5, 2'b00, 3'd2)); put(HALT);
        org(8'd15);  put(16'h1234);
        org(8'd16);  put(enc(3'b101, 2'b00, 3'd1, 3'd3, 2'b00, 3'd1)); put(HALT);
        org(8'd30);  put(16'h5678); put(16'h9ABC);
        org(8'd32);  put(ldst(3'b100, 3'd2, 3'd1, 5'd10)); put(ldst(3'b011, 3'd6, 3'd1, 5'd10));
                     put(enc(3'b101, 2'b00, 3'd6, 3'd7, 2'b00, 3'd1)); put(HALT);
        org(8'd48);  put(ldst(3'b100, 3'd1, 3'd1, 5'd25)); put(ldst(3'b011, 3'd6, 3'd1, 5'd25));
                     put(enc(3'b101, 2'b00, 3'd6, 3'd7, 2'b00, 3'd2)); put(HALT);
        org(8'd64);  put(movi(3'd1, 8'hFD)); put(movi(3'd2, 8'd4));
                     put(enc(3'b101, 2'b01, 3'd1, 3'd0, 2'b00, 3'd2)); put(16'h2301);
                     put(movi(3'd3, 8'd1)); put(movi(3'd3, 8'd2)); put(HALT);
        org(8'd96);  put(movi(3'd0, 8'h80));
                     put(enc(3'b110, 2'b00, 3'd0, 3'd3, 2'b10, 3'd0));
                     put(enc(3'b110, 2'b00, 3'd0, 3'd4, 2'b11, 3'd0));
                     put(enc(3'b110, 2'b00, 3'd0, 3'd5, 2'b01, 3'd0));
                     put(enc(3'b101, 2'b01, 3'd3, 3'd0, 2'b00, 3'd0));
                     put(enc(3'b101, 2'b01, 3'd0, 3'd0, 2'b00, 3'd0));
                     put(enc(3'b101, 2'b00, 3'd5, 3'd6, 2'b00, 3'd0)); put(HALT);
        org(8'd128); put(movi(3'd3, 8'd9)); put(ldst(3'b100, 3'd2, 3'd1, 5'd26)); put(HALT);
        org(8'd140); put(16'h0000);

        chk("rst_out", 32'(out), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        chk("rst_memrw", 32'({mem_rd, mem_wr}), 32'h0);
        chk("rst_memaddr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);

        // A: immediate moves, latency and halt
        @(negedge clk);
        rst_n = 1'b1;
        step(3); chk("A_latency", 32'(out), 32'h0);
        step(1); chk("A_mov_r1", 32'(out), 32'd5);
        step(3); chk("A_mov_r2", 32'(out), 32'd7);
        step(2); chk("A_not_halted", 32'(halted), 32'd0);
        step(1); chk("A_halted", 32'(halted), 32'd1);
        chk("A_pc", 32'(pc), 32'd3);
        chk("A_illegal", 32'(illegal), 32'd0);

        // B: ALU ops on registers kept from A
        do_reset(8'd8, 0);
        step(4); chk("B_add", 32'(out), 32'd12);
        step(3); chk("B_and", 32'(out), 32'd5);
        step(3); chk("B_mvn", 32'(out), 32'hFFF8);
        step(3); chk("B_halted", 32'(halted), 32'd1);
        chk("B_pc", 32'(pc), 32'd12);

        // C: register persistence across reset
        do_reset(8'd16, 0);
        step(4); chk("C_add_persist", 32'(out), 32'd10);

        // D: store then load, zero wait states
        do_reset(8'd32, 0);
        step(4);
        chk("D_str_wr", 32'({mem_rd, mem_wr}), 32'b01);
        chk("D_str_addr", 32'(mem_addr), 32'd15);
        chk("D_str_wdata", 32'(mem_wdata), 32'd7);
        chk("D_str_out_before", 32'(out), 32'd0);
        step(1); chk("D_str_out", 32'(out), 32'd7);
        chk("D_str_drop", 32'(mem_wr), 32'd0);
        step(3);
        chk("D_ldr_rd", 32'({mem_rd, mem_wr}), 32'b10);
        chk("D_ldr_addr", 32'(mem_addr), 32'd15);
        step(2); chk("D_ldr_out", 32'(out), 32'd7);
        step(3); chk("D_add_loaded", 32'(out), 32'd12);
        run_halt(20);
        chk("D_mem15", 32'(mem[15]), 32'd7);

        // E: same with 3 wait cycles on every request
        do_reset(8'd48, 3);
        step(8);
        chk("E_str_wait_wr", 32'(mem_wr), 32'd1);
        chk("E_str_wait_ready", 32'(mem_ready), 32'd0);
        chk("E_str_wait_addr", 32'(mem_addr), 32'd30);
        chk("E_str_wait_wdata", 32'(mem_wdata), 32'd5);
        step(2);
        chk("E_str_hold_wr", 32'(mem_wr), 32'd1);
        chk("E_str_hold_addr", 32'(mem_addr), 32'd30);
        chk("E_str_hold_out", 32'(out), 32'd0);
        step(1); chk("E_str_out", 32'(out), 32'd5);
        chk("E_str_drop", 32'(mem_wr), 32'd0);
        step(7);
        chk("E_ldr_wait_rd", 32'(mem_rd), 32'd1);
        chk("E_ldr_wait_addr", 32'(mem_addr), 32'd30);
        step(2);
        chk("E_ldr_hold_rd", 32'(mem_rd), 32'd1);
        chk("E_ldr_ready", 32'(mem_ready), 32'd1);
        step(2); chk("E_ldr_out", 32'(out), 32'd5);
        step(5); chk("E_add_before", 32'(out), 32'd5);
        step(1); chk("E_add", 32'(out), 32'd12);
        step(5); chk("E_not_halted", 32'(halted), 32'd0);
        step(1); chk("E_halted", 32'(halted), 32'd1);

        // H: reset during a store wait state
        do_reset(8'd128, 3);
        step(7); chk("H_mov", 32'(out), 32'd9);
        step(7);
        chk("H_wr_pending", 32'(mem_wr), 32'd1);
        chk("H_wr_addr", 32'(mem_addr), 32'd31);
        #2 rst_n = 1'b0;
        #1;
        chk("H_rst_wr", 32'(mem_wr), 32'd0);
        chk("H_rst_out", 32'(out), 32'd0);
        chk("H_rst_addr", 32'(mem_addr), 32'd0);
        chk("H_mem_untouched", 32'(mem[31]), 32'h9ABC);
        wait_cfg = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1);
        chk("H_restart_pc", 32'(pc), 32'd128);
        chk("H_restart_fetch", 32'({mem_rd, mem_addr}), 32'({1'b1, 8'd128}));
        run_halt(30);
        chk("H_out", 32'(out), 32'd7);
        chk("H_mem31", 32'(mem[31]), 32'd7);

        // F: CMP flags then a BLT word
        do_reset(8'd64, 0);
        step(7);
        chk("F_flags_before", 32'(flags), 32'h0);
        chk("F_mov_r2", 32'(out), 32'd4);
        step(3); chk("F_cmp_flags", 32'(flags), 32'b100);
`ifdef RISC_BRANCH_EN
        run_halt(20);
        chk("F_br_out", 32'(out), 32'd2);
        chk("F_br_pc", 32'(pc), 32'd71);
        chk("F_br_illegal", 32'(illegal), 32'd0);
`else
        step(3);
        chk("F_ill_halted", 32'(halted), 32'd1);
        chk("F_ill_illegal", 32'(illegal), 32'd1);
        chk("F_ill_pc", 32'(pc), 32'd68);
        chk("F_ill_out", 32'(out), 32'd4);
`endif

        // G: shifter, overflow/zero flags, modulo add
        do_reset(8'd96, 0);
        step(4); chk("G_movi_neg", 32'(out), 32'hFF80);
        step(3); chk("G_lsr", 32'(out), 32'h7FC0);
        step(3); chk("G_asr", 32'(out), 32'hFFC0);
        step(3); chk("G_lsl", 32'(out), 32'hFF00);
        step(3); chk("G_cmp_ovf", 32'(flags), 32'b110);
        step(3); chk("G_cmp_zero", 32'(flags), 32'b001);
        step(3); chk("G_add_wrap", 32'(out), 32'hFE80);
        step(3); chk("G_halted", 32'(halted), 32'd1);

        // I: undefined opcode 000
        do_reset(8'd140, 0);
        step(3); chk("I_not_halted", 32'(halted), 32'd0);
        step(1);
        chk("I_halted", 32'(halted), 32'd1);
        chk("I_illegal", 32'(illegal), 32'd1);
        chk("I_pc", 32'(pc), 32'd141);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
